// File: rtl/cpu_pkg.sv
// Purpose: shared definitions for the cpu_top slice.
// Contents: default data path width and the 4-bit opcode enumeration.
package cpu_pkg;

    localparam int unsigned CPU_WIDTH = 16;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned SHAMT_W   = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOT   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_NAND  = 4'd8,
        OP_NOR   = 4'd9,
        OP_XNOR  = 4'd10,
        OP_PASSA = 4'd11,
        OP_PASSB = 4'd12,
        OP_INC   = 4'd13,
        OP_DEC   = 4'd14,
        OP_CLR   = 4'd15
    } op_e;

endpackage

// File: rtl/cpu_if.sv
// Purpose: operation bus between an issuer (master) and cpu_top (slave).
// Signals: op_code, rs1_in, rs2_in, cin, bin (issuer -> cpu);
//          result, cout, zero (cpu -> issuer, registered).
interface cpu_if #(
    parameter int unsigned WIDTH = cpu_pkg::CPU_WIDTH
);
    logic [cpu_pkg::OP_W-1:0] op_code;
    logic [WIDTH-1:0]         rs1_in;
    logic [WIDTH-1:0]         rs2_in;
    logic                     cin;
    logic                     bin;
    logic [WIDTH-1:0]         result;
    logic                     cout;
    logic                     zero;

    modport master (
        output op_code, rs1_in, rs2_in, cin, bin,
        input  result, cout, zero
    );

    modport slave (
        input  op_code, rs1_in, rs2_in, cin, bin,
        output result, cout, zero
    );
endinterface

// File: rtl/alu_core.sv
// Purpose: purely combinational ALU computing next result and carry/borrow/shift-out.
// Ports: op_code (operation), a/b (operands), cin (ADD carry-in), bin (SUB borrow-in),
//        result_c / cout_c (combinational next-state values).
module alu_core
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = CPU_WIDTH
) (
    input  logic [OP_W-1:0]  op_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             bin,
    output logic [WIDTH-1:0] result_c,
    output logic             cout_c
);

    op_e                op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH:0]     inc_w;
    logic [WIDTH:0]     dec_w;
    logic [WIDTH:0]     shl_w;
    logic [WIDTH:0]     shr_w;

    assign op    = op_e'(op_code);
    assign shamt = b[SHAMT_W-1:0];

    // One extra bit on each arithmetic path holds the carry or borrow out.
    assign add_w = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    assign sub_w = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bin);
    assign inc_w = {1'b0, a} + (WIDTH+1)'(1);
    assign dec_w = {1'b0, a} - (WIDTH+1)'(1);

    // Guard bit catches the last bit shifted out; it stays 0 for a zero shift.
    assign shl_w = {1'b0, a} << shamt;
    assign shr_w = {a, 1'b0} >> shamt;

    // Operation select; cin/bin are only referenced on their own ops.
    always_comb begin
        result_c = '0;
        cout_c   = 1'b0;
        case (op)
            OP_ADD:   {cout_c, result_c} = add_w;
            OP_SUB:   {cout_c, result_c} = sub_w;
            OP_AND:   result_c = a & b;
            OP_OR:    result_c = a | b;
            OP_XOR:   result_c = a ^ b;
            OP_NOT:   result_c = ~a;
            OP_SHL:   {cout_c, result_c} = shl_w;
            OP_SHR:   {result_c, cout_c} = shr_w;
            OP_NAND:  result_c = ~(a & b);
            OP_NOR:   result_c = ~(a | b);
            OP_XNOR:  result_c = ~(a ^ b);
            OP_PASSA: result_c = a;
            OP_PASSB: result_c = b;
            OP_INC:   {cout_c, result_c} = inc_w;
            OP_DEC:   {cout_c, result_c} = dec_w;
            OP_CLR:   result_c = '0;
            default:  result_c = '0;
        endcase
    end

endmodule

// File: rtl/cpu_top.sv
// Purpose: single-cycle ALU datapath with registered result, carry and zero flag.
// Ports: clk, rst_n (synchronous, active-low), bus (cpu_if slave: operation in,
//        registered result/cout/zero out, one-cycle latency, new op every cycle).
module cpu_top
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = CPU_WIDTH
) (
    input  logic  clk,
    input  logic  rst_n,
    cpu_if.slave  bus
);

    logic [WIDTH-1:0] alu_result_c;
    logic             alu_cout_c;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             zero_q;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op_code  (bus.op_code),
        .a        (bus.rs1_in),
        .b        (bus.rs2_in),
        .cin      (bus.cin),
        .bin      (bus.bin),
        .result_c (alu_result_c),
        .cout_c   (alu_cout_c)
    );

    // Output registers; reset discards the op presented in that cycle.
    // zero is derived from the value being written, not the held one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= alu_result_c;
            cout_q   <= alu_cout_c;
            zero_q   <= (alu_result_c == '0);
        end
    end

    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.zero   = zero_q;

endmodule

// File: tb/tb_cpu_top.sv
// Purpose: self-checking bench for cpu_top; directed vectors then 1000 random ops
// with a reset pulse mid-run, expected values queued at drive time and checked
// one cycle later.
module tb_cpu_top;

    typedef struct {
        logic [15:0] r;
        logic        c;
        logic        z;
        string       tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    exp_t sb_q[$];

    cpu_if bus ();

    cpu_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: integer arithmetic and bit-at-a-time shifting.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic ci, input logic bi);
        exp_t        m;
        int unsigned s;
        logic [15:0] t;
        int          n;
        m.r = 16'h0000;
        m.c = 1'b0;
        m.tag = "rand";
        case (op)
            4'd0: begin
                s = int'(a) + int'(b) + (ci ? 1 : 0);
                m.r = s[15:0];
                m.c = s[16];
            end
            4'd1: begin
                m.r = a - b - (bi ? 16'd1 : 16'd0);
                m.c = (int'(a) < int'(b) + (bi ? 1 : 0));
            end
            4'd2:  m.r = a & b;
            4'd3:  m.r = a | b;
            4'd4:  m.r = a ^ b;
            4'd5:  m.r = ~a;
            4'd6: begin
                t = a;
                n = int'(b[3:0]);
                for (int k = 0; k < n; k++) begin
                    m.c = t[15];
                    t = {t[14:0], 1'b0};
                end
                m.r = t;
            end
            4'd7: begin
                t = a;
                n = int'(b[3:0]);
                for (int k = 0; k < n; k++) begin
                    m.c = t[0];
                    t = {1'b0, t[15:1]};
                end
                m.r = t;
            end
            4'd8:  m.r = ~(a & b);
            4'd9:  m.r = ~(a | b);
            4'd10: m.r = ~(a ^ b);
            4'd11: m.r = a;
            4'd12: m.r = b;
            4'd13: begin
                m.r = a + 16'd1;
                m.c = (a == 16'hFFFF);
            end
            4'd14: begin
                m.r = a - 16'd1;
                m.c = (a == 16'h0000);
            end
            default: m.r = 16'h0000;
        endcase
        m.z = (m.r == 16'h0000);
        return m;
    endfunction

    // Drive one op, queue its expectation, then check the output after the edge.
    task automatic apply(input logic r, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic ci, input logic bi,
                         input logic [15:0] er, input logic ec, input string tag);
        exp_t e;
        rst_n       = r;
        bus.op_code = op;
        bus.rs1_in  = a;
        bus.rs2_in  = b;
        bus.cin     = ci;
        bus.bin     = bi;
        e.r   = r ? er : 16'h0000;
        e.c   = r ? ec : 1'b0;
        e.z   = (e.r == 16'h0000);
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        vectors++;
        assert ({bus.result, bus.cout, bus.zero} === {e.r, e.c, e.z}) else begin
            miscompares++;
            $error("FAIL %s: observed result=%h cout=%b zero=%b expected result=%h cout=%b zero=%b",
                   e.tag, bus.result, bus.cout, bus.zero, e.r, e.c, e.z);
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        bi;
        logic        r;
        exp_t        m;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.op_code = 4'd0;
        bus.rs1_in  = 16'd0;
        bus.rs2_in  = 16'd0;
        bus.cin     = 1'b0;
        bus.bin     = 1'b0;
        @(negedge clk);

        // Reset held two cycles with an ADD presented
        apply(1'b0, 4'd0, 16'd5, 16'd7, 1'b0, 1'b0, 16'h0000, 1'b0, "reset0");
        apply(1'b0, 4'd0, 16'd5, 16'd7, 1'b0, 1'b0, 16'h0000, 1'b0, "reset1");

        // Arithmetic
        apply(1'b1, 4'd0, 16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, "add_cin");
        apply(1'b1, 4'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, "add_wrap");
        apply(1'b1, 4'd1, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, "sub_wrap");
        apply(1'b1, 4'd1, 16'h0003, 16'h0005, 1'b0, 1'b0, 16'hFFFE, 1'b1, "sub_neg");
        apply(1'b1, 4'd1, 16'd10,   16'd3,    1'b0, 1'b1, 16'h0006, 1'b0, "sub_bin");

        // Logic ops, with unknown cin/bin that must not leak through
        apply(1'b1, 4'd2,  16'hF0F0, 16'hFF00, 1'bx, 1'bx, 16'hF000, 1'b0, "and");
        apply(1'b1, 4'd3,  16'hF0F0, 16'hFF00, 1'bx, 1'bx, 16'hFFF0, 1'b0, "or");
        apply(1'b1, 4'd4,  16'hF0F0, 16'hFF00, 1'b1, 1'b1, 16'h0FF0, 1'b0, "xor");
        apply(1'b1, 4'd5,  16'hF0F0, 16'hFF00, 1'b1, 1'b1, 16'h0F0F, 1'b0, "not");
        apply(1'b1, 4'd8,  16'hF0F0, 16'hFF00, 1'b0, 1'b0, 16'h0FFF, 1'b0, "nand");
        apply(1'b1, 4'd9,  16'hF0F0, 16'hFF00, 1'b0, 1'b0, 16'h000F, 1'b0, "nor");
        apply(1'b1, 4'd10, 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 16'hF00F, 1'b0, "xnor");
        apply(1'b1, 4'd11, 16'hF0F0, 16'hFF00, 1'b1, 1'b1, 16'hF0F0, 1'b0, "passa");
        apply(1'b1, 4'd12, 16'hF0F0, 16'hFF00, 1'b1, 1'b1, 16'hFF00, 1'b0, "passb");

        // Shifts: only B[3:0] counts
        apply(1'b1, 4'd6, 16'h8001, 16'h0011, 1'b0, 1'b0, 16'h0002, 1'b1, "shl1");
        apply(1'b1, 4'd7, 16'h8001, 16'h0011, 1'b0, 1'b0, 16'h4000, 1'b1, "shr1");
        apply(1'b1, 4'd6, 16'h8001, 16'hFFF0, 1'b1, 1'b1, 16'h8001, 1'b0, "shl0");
        apply(1'b1, 4'd7, 16'hC000, 16'h000F, 1'b0, 1'b0, 16'h0001, 1'b1, "shr15");

        // INC/DEC/CLR
        apply(1'b1, 4'd13, 16'hFFFF, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, "inc_wrap");
        apply(1'b1, 4'd14, 16'h0000, 16'h1234, 1'b1, 1'b1, 16'hFFFF, 1'b1, "dec_wrap");
        apply(1'b1, 4'd14, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0004, 1'b0, "dec");
        apply(1'b1, 4'd15, 16'h1234, 16'h5678, 1'b1, 1'b1, 16'h0000, 1'b0, "clr");

        // Reset wins over a presented op, then the next op proceeds normally
        apply(1'b0, 4'd11, 16'hABCD, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, "rst_prio");
        apply(1'b1, 4'd11, 16'h1357, 16'h0000, 1'b0, 1'b0, 16'h1357, 1'b0, "post_rst");

        // Back-to-back random ops with one reset pulse
        for (int i = 0; i < 1000; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = 16'($urandom);
            ci = 1'($urandom_range(0, 1));
            bi = 1'($urandom_range(0, 1));
            r  = (i != 500);
            m  = model(op, a, b, ci, bi);
            apply(r, op, a, b, ci, bi, m.r, m.c, r ? "rand" : "rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
